hand_accumulator: RTL
=====================

Name: hand_accumulator

Overview:
Sequential, parametrised successor to the combinational hand scorer. It accepts cards one per handshake, maps each rank to its baccarat value, and keeps a registered running score mod MODULUS. It also tracks card count, natural detection, and overflow/illegal-card errors. It sits between the dealer/deal-control FSM and the win-logic, and holds either player or banker hand state across deals.

Parameters:
CARD_W, 4, width of rank input (ranks 1..13 legal; 0 = no card)
MAX_CARDS, 3, cards accepted per hand before FULL
MODULUS, 10, score modulus; must be > 9
FACE_MIN, 10, lowest rank whose value is 0 (10,J,Q,K)

Ports:
slow_clock  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
new_hand  input  1  synchronous clear of hand state (one-cycle pulse)
card_valid  input  1  card present this cycle
card  input  CARD_W  card rank
card_ready  output  1  high when a card will be accepted this cycle
total  output  4  registered score, 0..MODULUS-1
card_count  output  $clog2(MAX_CARDS+1)  cards accepted this hand
score_valid  output  1  one-cycle pulse the cycle after each accepted card
natural  output  1  high when card_count==2 and total is 8 or 9
hand_full  output  1  high in FULL state
err  output  1  sticky: illegal rank accepted-attempt or card offered while FULL

Behaviour:
- Reset (async, active-high): state=EMPTY, total=0, card_count=0, score_valid=0, natural=0, err=0, hand_full=0; card_ready=1 once reset deasserts.
- Value map (combinational): rank 1..FACE_MIN-1 -> rank; rank FACE_MIN..13 -> 0; rank 0 or >13 -> illegal.
- Accept = card_valid & card_ready & legal rank. On accept: total <= (total+value >= MODULUS) ? total+value-MODULUS : total+value; card_count <= card_count+1; score_valid <= 1 next cycle. Latency card-in -> total updated is 1 cycle.
- Illegal rank with card_valid & card_ready: not accepted, total/count unchanged, err<=1, no score_valid.
- States: EMPTY (count=0) -> PARTIAL on first accept; PARTIAL -> FULL when the accept makes count==MAX_CARDS; any state -> EMPTY on new_hand. With MAX_CARDS=1, EMPTY -> FULL directly.
- card_ready = (state != FULL). card_valid while FULL: ignored, err<=1.
- new_hand clears total, card_count, err, natural, and returns to EMPTY. If new_hand and card_valid occur in the same cycle, the clear applies first and the card is accepted as card 1 of the new hand (total=value, count=1).
- natural is registered and recomputed on every accept; it is cleared by the third card or by new_hand.
- score_valid is low in every cycle that has no accept in the previous cycle.
- Reset mid-hand discards everything immediately, without waiting for a clock edge.
- Sum width is internal 5 bits; total never reaches or exceeds MODULUS.

Test Plan:
- Reset asserted mid-hand (after 2 cards) asynchronously -> total=0, count=0, err=0 before next edge; card_ready=1 after release.
- new_hand; accept A(1),4,K(13) on consecutive cycles -> total 1,5,5; count 1,2,3; score_valid each cycle after accept; hand_full=1 after third.
- new_hand; accept 2,5 -> total=7, count=2, natural=0; then 5,3,8 in new hand -> totals 5,8,6; natural=1 after 5,3 and cleared after 8.
- FULL hand, offer card 7 -> total unchanged, count=3, err=1, no score_valid; new_hand -> err=0, EMPTY.
- Offer rank 0 and rank 14 in EMPTY -> not accepted, count=0, err=1; legal 9 afterwards still accepted (total=9).
- new_hand and card_valid(rank 6) in the same cycle on a hand with total=4 -> next cycle total=6, count=1.

Source files
------------

// File: rtl/hand_accumulator.sv
// Baccarat hand accumulator: accepts one card per handshake, keeps a
// registered running score mod MODULUS, and tracks the card count,
// natural detection and sticky error state for one hand.
module hand_accumulator #(
  parameter int CARD_W    = 4,
  parameter int MAX_CARDS = 3,
  parameter int MODULUS   = 10,
  parameter int FACE_MIN  = 10
) (
  input  logic                               slow_clock,
  input  logic                               reset,
  input  logic                               new_hand,
  input  logic                               card_valid,
  input  logic [CARD_W-1:0]                  card,
  output logic                               card_ready,
  output logic [3:0]                         total,
  output logic [$clog2(MAX_CARDS+1)-1:0]     card_count,
  output logic                               score_valid,
  output logic                               natural,
  output logic                               hand_full,
  output logic                               err
);

  localparam int CNT_W = $clog2(MAX_CARDS+1);
  localparam int SUM_W = 5;

  localparam logic [CARD_W-1:0] RANK_MAX  = CARD_W'(13);
  localparam logic [CARD_W-1:0] FACE_RANK = CARD_W'(FACE_MIN);
  localparam logic [SUM_W-1:0]  MOD_S     = SUM_W'(MODULUS);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_CARDS);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

  // Rank 0 means "no card"; anything above King is not a real card.
  function automatic logic card_legal(input logic [CARD_W-1:0] rank);
    return (rank != '0) && (rank <= RANK_MAX);
  endfunction

  // Tens and court cards count zero, pips count their face value.
  function automatic logic [SUM_W-1:0] card_value(input logic [CARD_W-1:0] rank);
    return (rank >= FACE_RANK) ? '0 : SUM_W'(rank);
  endfunction

  // Both operands are below MODULUS, so one conditional subtract wraps the sum.
  function automatic logic [3:0] wrap_add(input logic [3:0] acc,
                                          input logic [SUM_W-1:0] val);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, acc} + val;
    if (sum >= MOD_S) begin
      sum = sum - MOD_S;
    end
    return sum[3:0];
  endfunction

  state_t             state_p1, state_p0;
  logic [3:0]         total_p1, total_p0;
  logic [CNT_W-1:0]   count_p1, count_p0;
  logic               err_p1, err_p0;
  logic               nat_p1, nat_p0;
  logic               vld_p1, vld_p0;

  state_t             base_state;
  logic [3:0]         base_total;
  logic [CNT_W-1:0]   base_count;
  logic               base_err;
  logic               base_nat;
  logic               ready_p0;
  logic               legal_p0;

  // Next-state and datapath: new_hand clears first, then the offered card
  // is judged against the cleared hand so it can become card 1.
  always_comb begin
    base_state = new_hand ? EMPTY : state_p1;
    base_total = new_hand ? 4'd0 : total_p1;
    base_count = new_hand ? '0 : count_p1;
    base_err   = new_hand ? 1'b0 : err_p1;
    base_nat   = new_hand ? 1'b0 : nat_p1;

    ready_p0 = (base_state != FULL);
    legal_p0 = card_legal(card);

    state_p0 = base_state;
    total_p0 = base_total;
    count_p0 = base_count;
    err_p0   = base_err;
    nat_p0   = base_nat;
    vld_p0   = 1'b0;

    if (card_valid) begin
      if (!ready_p0 || !legal_p0) begin
        err_p0 = 1'b1;
      end else begin
        vld_p0   = 1'b1;
        total_p0 = wrap_add(base_total, card_value(card));
        count_p0 = base_count + CNT_W'(1);
        nat_p0   = (int'(count_p0) == 2) && ((total_p0 == 4'd8) || (total_p0 == 4'd9));
        state_p0 = (count_p0 == CNT_MAX) ? FULL : PARTIAL;
      end
    end
  end

  // Hand state register; reset drops the hand immediately.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      state_p1 <= EMPTY;
    end else begin
      state_p1 <= state_p0;
    end
  end

  // Score, count, flags and the one-cycle score_valid pulse.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      total_p1 <= 4'd0;
      count_p1 <= '0;
      err_p1   <= 1'b0;
      nat_p1   <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      total_p1 <= total_p0;
      count_p1 <= count_p0;
      err_p1   <= err_p0;
      nat_p1   <= nat_p0;
      vld_p1   <= vld_p0;
    end
  end

  assign card_ready  = (state_p1 != FULL);
  assign hand_full   = (state_p1 == FULL);
  assign total       = total_p1;
  assign card_count  = count_p1;
  assign score_valid = vld_p1;
  assign natural     = nat_p1;
  assign err         = err_p1;

endmodule
